// File: rtl/wb_burst_reader.sv
// Pipelined Wishbone read initiator streaming a word block out through a 16-entry FIFO; first word leaves 1 cycle after its ack.
// Backpressure: requests are issued only while FIFO fill plus outstanding reads is below depth, so read data is never dropped.
module wb_burst_reader #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int FIFO_DEPTH_POT = 4
) (
    input  logic                      sys_clk,
    input  logic                      external_resetn,
    input  logic                      start_i,
    input  logic [ADDRESS_WIDTH-1:0]  base_addr_i,
    input  logic [LEN_WIDTH-1:0]      len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [ADDRESS_WIDTH-1:0]  wb_addr_o,
    output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
    output logic [DATA_WIDTH-1:0]     wb_wdata_o,
    input  logic [DATA_WIDTH-1:0]     wb_rdata_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i,
    input  logic                      wb_rty_i,
    input  logic                      wb_stall_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      valid_o,
    input  logic                      ready_i
);
    localparam int DEPTH = 1 << FIFO_DEPTH_POT;
    localparam int CW    = FIFO_DEPTH_POT + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                    state;
    logic [LEN_WIDTH-1:0]      req_left;
    logic [CW-1:0]             outst;
    logic [CW-1:0]             mem_count;
    logic [CW-1:0]             fifo_count;
    logic [FIFO_DEPTH_POT-1:0] wr_ptr;
    logic [FIFO_DEPTH_POT-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      load;
    logic                      abort;

    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = '1;
    assign wb_wdata_o = '0;

    // Fill level counts the output register as well, so capacity is exactly DEPTH words.
    assign fifo_count = mem_count + CW'(valid_o);
    assign wb_stb_o   = (state == REQ) && (req_left != '0) &&
                        (({1'b0, fifo_count} + {1'b0, outst}) < (CW+1)'(DEPTH));
    assign accept     = wb_stb_o && !wb_stall_i;
    assign abort      = wb_cyc_o && (wb_err_i || wb_rty_i);
    assign push       = wb_cyc_o && wb_ack_i && !abort;
    assign pop        = valid_o && ready_i;
    assign load       = (mem_count != '0) && (!valid_o || ready_i);

    always_ff @(posedge sys_clk or negedge external_resetn) begin
        if (!external_resetn) begin
            state     <= IDLE;
            req_left  <= '0;
            outst     <= '0;
            wb_cyc_o  <= 1'b0;
            wb_addr_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        err_o <= 1'b0;
                        if (len_i != '0) begin
                            state     <= REQ;
                            wb_cyc_o  <= 1'b1;
                            busy_o    <= 1'b1;
                            wb_addr_o <= base_addr_i;
                            req_left  <= len_i;
                            outst     <= '0;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        state    <= IDLE;
                        wb_cyc_o <= 1'b0;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        err_o    <= 1'b1;
                        outst    <= '0;
                        req_left <= '0;
                    end else begin
                        if (accept) begin
                            wb_addr_o <= wb_addr_o + ADDRESS_WIDTH'(1);
                            req_left  <= req_left - LEN_WIDTH'(1);
                        end
                        outst <= outst + CW'(accept) - CW'(push);
                        if (state == REQ && accept && req_left == LEN_WIDTH'(1)) begin
                            state <= WAIT;
                        end
                        if (state == WAIT && push && outst == CW'(1)) begin
                            state    <= IDLE;
                            wb_cyc_o <= 1'b0;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Output register refills from the array; no fall-through, so a push is visible one cycle later.
    always_ff @(posedge sys_clk or negedge external_resetn) begin
        if (!external_resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            valid_o   <= 1'b0;
            data_o    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_POT'(1);
            end
            if (load) begin
                data_o <= mem[rd_ptr];
                rd_ptr <= rd_ptr + FIFO_DEPTH_POT'(1);
            end
            mem_count <= mem_count + CW'(push) - CW'(load);
            if (load) begin
                valid_o <= 1'b1;
            end else if (pop) begin
                valid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wb_rdata_i;
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge sys_clk) disable iff (!external_resetn)
        !(push && fifo_count == CW'(DEPTH)));
`endif

endmodule

// File: tb/tb_wb_burst_reader.sv
// Scoreboard bench: stimulus queues expected addresses, data and done/err; a negedge monitor/responder checks them.
module tb_wb_burst_reader;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          sys_clk = 1'b0;
    logic          external_resetn = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          busy_o, done_o, err_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [3:0]    wb_sel_o;
    logic [DW-1:0] wb_wdata_o;
    logic [DW-1:0] wb_rdata_i = '0;
    logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;

    wb_burst_reader dut (
        .sys_clk(sys_clk), .external_resetn(external_resetn),
        .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_sel_o(wb_sel_o), .wb_wdata_o(wb_wdata_o),
        .wb_rdata_i(wb_rdata_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } req_t;

    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic          exp_done[$];
    req_t          pend[$];

    int tests = 0, fails = 0;
    int cyc_n = 0, accepted = 0, delivered = 0, dones = 0, cyc_seen = 0;
    int ack_num = 0, err_on_ack = 0, stall_pct = 0, lat_min = 1, lat_max = 1;
    int first_acc = -1, last_acc = -1;
    logic          was_stalled = 1'b0;
    logic [AW-1:0] held_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not expected or bound expired", name);
    endtask

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {8'hD0, a};
    endfunction

    // Monitor first, then responder drives the inputs for the coming edge.
    initial forever begin
        @(negedge sys_clk);
        cyc_n++;
        if (!external_resetn) begin
            pend.delete();
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
            was_stalled = 1'b0;
            continue;
        end
        if (valid_o && ready_i) begin
            if (exp_data.size() == 0) flag("extra_data");
            else check("data", data_o, exp_data.pop_front());
            delivered++;
        end
        if (done_o) begin
            dones++;
            if (exp_done.size() == 0) flag("extra_done");
            else check("err_at_done", err_o, exp_done.pop_front());
        end
        if (wb_cyc_o) cyc_seen++;
        if (was_stalled && wb_stb_o) check("addr_hold", wb_addr_o, held_addr);

        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rdata_i = '0;
        if (!wb_cyc_o) begin
            pend.delete();
        end else if (pend.size() > 0 && pend[0].due <= cyc_n) begin
            ack_num++;
            if (ack_num == err_on_ack) begin
                wb_err_i = 1'b1;
                pend.delete();
            end else begin
                wb_ack_i   = 1'b1;
                wb_rdata_i = word_of(pend[0].addr);
                void'(pend.pop_front());
            end
        end
        wb_stall_i  = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
        was_stalled = wb_stb_o && wb_stall_i;
        held_addr   = wb_addr_o;
        if (wb_stb_o && !wb_stall_i && !wb_err_i) begin
            accepted++;
            if (first_acc < 0) first_acc = cyc_n;
            last_acc = cyc_n;
            if (exp_addr.size() == 0) flag("extra_request");
            else check("req_addr", wb_addr_o, exp_addr.pop_front());
            check("credit_limit", 64'((accepted - delivered) <= 16), 64'd1);
            pend.push_back('{wb_addr_o, cyc_n + int'($urandom_range(lat_max, lat_min))});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic burst(input string name, input logic [AW-1:0] base, input int len,
                         input int errn, input int hold, input bit poke, input bit gapchk);
        int t;
        int cyc0, dones0;
        accepted = 0; delivered = 0; ack_num = 0; err_on_ack = errn;
        first_acc = -1; last_acc = -1;
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(base + AW'(i));
            if (errn == 0 || i < errn - 1) exp_data.push_back(word_of(base + AW'(i)));
        end
        exp_done.push_back(errn != 0);
        cyc0 = cyc_seen; dones0 = dones;
        start_i = 1'b1; base_addr_i = base; len_i = LW'(len);
        step(1);
        start_i = 1'b0;
        check({name, "_busy"}, busy_o, 64'(len != 0));
        check({name, "_cyc"}, wb_cyc_o, 64'(len != 0));
        check({name, "_err_clear"}, err_o, 64'd0);
        if (len != 0) check({name, "_first_addr"}, wb_addr_o, base);
        t = 0;
        while ((exp_data.size() != 0 || exp_done.size() != 0) && t < 5000) begin
            if (poke && t == 10) begin
                start_i = 1'b1; base_addr_i = 24'h000777; len_i = 16'd5;
            end else begin
                start_i = 1'b0;
            end
            if (hold > 0 && t == hold) begin
                check({name, "_bp_accepted"}, accepted, 64'd16);
                check({name, "_bp_stb_low"}, wb_stb_o, 64'd0);
                ready_i = 1'b1;
            end
            step(1);
            t++;
        end
        start_i = 1'b0;
        if (t >= 5000) flag({name, "_timeout"});
        step(3);
        check({name, "_done_count"}, dones - dones0, 64'd1);
        check({name, "_idle"}, busy_o, 64'd0);
        if (errn == 0) check({name, "_all_requests"}, exp_addr.size(), 64'd0);
        else exp_addr.delete();
        if (len == 0) check({name, "_no_cyc"}, cyc_seen - cyc0, 64'd0);
        if (gapchk) check({name, "_no_stb_gap"}, last_acc - first_acc, 64'(len - 1));
    endtask

    initial begin
        #2 external_resetn = 1'b0;
        #1;
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_addr", wb_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("const_we", wb_we_o, 0);
        check("const_sel", wb_sel_o, 64'hF);
        check("const_wdata", wb_wdata_o, 0);
        step(3);
        external_resetn = 1'b1;
        step(2);

        ready_i = 1'b1;
        burst("single", 24'h000100, 1, 0, 0, 1'b0, 1'b0);
        check("single_err", err_o, 0);
        burst("stream", 24'h000200, 64, 0, 0, 1'b1, 1'b1);

        ready_i = 1'b0;
        burst("backpressure", 24'h001000, 40, 0, 100, 1'b0, 1'b0);

        ready_i = 1'b1; stall_pct = 50; lat_min = 1; lat_max = 4;
        burst("stall_lat", 24'h002000, 33, 0, 0, 1'b0, 1'b0);
        stall_pct = 0; lat_max = 1;

        burst("abort", 24'h003000, 10, 5, 0, 1'b0, 1'b0);
        check("abort_err_sticky", err_o, 1);
        burst("after_abort", 24'h003100, 1, 0, 0, 1'b0, 1'b0);
        burst("len_zero", 24'h004000, 0, 0, 0, 1'b0, 1'b0);
        burst("wrap", 24'hFFFFFF, 2, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a burst with words parked in the FIFO.
        ready_i = 1'b0; accepted = 0; delivered = 0; ack_num = 0; err_on_ack = 0;
        for (int i = 0; i < 20; i++) exp_addr.push_back(24'h005000 + AW'(i));
        start_i = 1'b1; base_addr_i = 24'h005000; len_i = 16'd20;
        step(1);
        start_i = 1'b0;
        step(8);
        check("pre_rst_valid", valid_o, 1);
        external_resetn = 1'b0;
        #1;
        check("midrst_cyc", wb_cyc_o, 0);
        check("midrst_stb", wb_stb_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy_o, 0);
        exp_addr.delete(); exp_data.delete(); exp_done.delete();
        step(2);
        external_resetn = 1'b1;
        ready_i = 1'b1;
        step(5);
        check("postrst_fifo_empty", valid_o, 0);
        burst("post_reset", 24'h006000, 3, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
